// File: rtl/wb_port_arbiter_pkg.sv
// Shared types and defaults for the writeback port arbiter slice.
package wb_port_arbiter_pkg;

   localparam int unsigned PHY_DEST_W    = 7;
   localparam int unsigned SEQ_W         = 8;
   localparam int unsigned DATA_W        = 32;

   localparam int unsigned DEF_NUM_LANES = 4;
   localparam int unsigned DEF_NUM_PORTS = 2;
   localparam int unsigned DEF_QDEPTH    = 2;
   localparam int unsigned DEF_CNT_W     = 16;

   typedef struct packed {
      logic                  valid;
      logic [PHY_DEST_W-1:0] phyDest;
      logic [SEQ_W-1:0]      seqNo;
      logic [DATA_W-1:0]     data;
   } wbPkt;

   localparam int unsigned WB_PKT_SIZE = $bits(wbPkt);

   // Single-step modulo for indices that can exceed n by less than n.
   function automatic int unsigned wrap_lane(input int unsigned idx, input int unsigned n);
      return (idx >= n) ? idx - n : idx;
   endfunction

endpackage

// File: rtl/wb_lane_queue.sv
// Per-lane circular FIFO of writeback packets with occupancy-based ready and flush.
module wb_lane_queue
   import wb_port_arbiter_pkg::*;
#(
   parameter int unsigned QDEPTH = DEF_QDEPTH
) (
   input  logic clk,
   input  logic reset,
   input  logic flush_i,
   input  wbPkt enqPkt_i,
   input  logic deq_i,
   output wbPkt headPkt_c_o,
   output logic notEmpty_c_o,
   output logic ready_c_o
);

   localparam int unsigned PTR_W = $clog2(QDEPTH);
   localparam int unsigned OCC_W = PTR_W + 1;

   logic [WB_PKT_SIZE-1:0] mem_q [QDEPTH];
   logic [PTR_W-1:0]       wrPtr_q, wrPtr_d;
   logic [PTR_W-1:0]       rdPtr_q, rdPtr_d;
   logic [OCC_W-1:0]       count_q, count_d;
   logic                   enq, deq;

   // Ready looks only at the registered count: a full queue refuses even if drained this cycle.
   assign ready_c_o    = (count_q != OCC_W'(QDEPTH));
   assign notEmpty_c_o = (count_q != '0);
   assign headPkt_c_o  = wbPkt'(mem_q[rdPtr_q]);

   assign enq = enqPkt_i.valid & ready_c_o & ~flush_i;
   assign deq = deq_i & notEmpty_c_o & ~flush_i;

   always_comb begin
      wrPtr_d = wrPtr_q;
      rdPtr_d = rdPtr_q;
      count_d = count_q;
      if (flush_i) begin
         wrPtr_d = '0;
         rdPtr_d = '0;
         count_d = '0;
      end else begin
         if (enq) wrPtr_d = wrPtr_q + 1'b1;
         if (deq) rdPtr_d = rdPtr_q + 1'b1;
         count_d = count_q + OCC_W'(enq) - OCC_W'(deq);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wrPtr_q <= '0;
         rdPtr_q <= '0;
         count_q <= '0;
      end else begin
         wrPtr_q <= wrPtr_d;
         rdPtr_q <= rdPtr_d;
         count_q <= count_d;
      end
   end

   // Storage needs no reset; occupancy gates every read.
   always_ff @(posedge clk) begin
      if (enq) mem_q[wrPtr_q] <= enqPkt_i;
   end

endmodule

// File: rtl/wb_port_arbiter.sv
// Round-robin drain of per-lane writeback queues onto NUM_PORTS registered writeback ports.
module wb_port_arbiter
   import wb_port_arbiter_pkg::*;
#(
   parameter int unsigned NUM_LANES = DEF_NUM_LANES,
   parameter int unsigned NUM_PORTS = DEF_NUM_PORTS,
   parameter int unsigned QDEPTH    = DEF_QDEPTH,
   parameter int unsigned CNT_W     = DEF_CNT_W
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         recoverFlag_i,
   input  wbPkt                         lanePkt_i     [NUM_LANES],
   output logic                         laneReady_o   [NUM_LANES],
   output wbPkt                         portPkt_o     [NUM_PORTS],
   output logic [$clog2(NUM_LANES)-1:0] portLane_o    [NUM_PORTS],
   output logic [CNT_W-1:0]             conflictCnt_o
);

   localparam int unsigned LANE_W = $clog2(NUM_LANES);
   localparam int unsigned PORT_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

   wbPkt              head     [NUM_LANES];
   logic [NUM_LANES-1:0] notEmpty;
   logic [NUM_LANES-1:0] grant;

   logic [LANE_W-1:0] rrPtr_q, rrPtr_d;
   wbPkt              portPkt_q  [NUM_PORTS];
   wbPkt              portPkt_d  [NUM_PORTS];
   logic [LANE_W-1:0] portLane_q [NUM_PORTS];
   logic [LANE_W-1:0] portLane_d [NUM_PORTS];
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   genvar gl;
   generate
      for (gl = 0; gl < NUM_LANES; gl++) begin : g_lane
         wb_lane_queue #(.QDEPTH(QDEPTH)) u_queue (
            .clk          (clk),
            .reset        (reset),
            .flush_i      (recoverFlag_i),
            .enqPkt_i     (lanePkt_i[gl]),
            .deq_i        (grant[gl]),
            .headPkt_c_o  (head[gl]),
            .notEmpty_c_o (notEmpty[gl]),
            .ready_c_o    (laneReady_o[gl])
         );
      end
   endgenerate

   // Scan from rrPtr; the k-th non-empty lane found goes to port k.
   always_comb begin
      int unsigned lane;
      int unsigned nGrant;
      int unsigned nBusy;
      lane    = 0;
      nGrant  = 0;
      nBusy   = 0;
      grant   = '0;
      rrPtr_d = rrPtr_q;
      for (int unsigned p = 0; p < NUM_PORTS; p++) begin
         portPkt_d[p]  = '0;
         portLane_d[p] = '0;
      end
      for (int unsigned i = 0; i < NUM_LANES; i++) begin
         lane = wrap_lane(32'(rrPtr_q) + i, NUM_LANES);
         if (notEmpty[LANE_W'(lane)]) begin
            nBusy = nBusy + 1;
            if (nGrant < NUM_PORTS) begin
               grant[LANE_W'(lane)]              = 1'b1;
               portPkt_d[PORT_W'(nGrant)]        = head[LANE_W'(lane)];
               portPkt_d[PORT_W'(nGrant)].valid  = 1'b1;
               portLane_d[PORT_W'(nGrant)]       = LANE_W'(lane);
               rrPtr_d = LANE_W'(wrap_lane(lane + 1, NUM_LANES));
               nGrant  = nGrant + 1;
            end
         end
      end
      cnt_d = cnt_q;
      if ((nBusy > NUM_PORTS) && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
   end

   // Recovery clears arbitration state but keeps the conflict count frozen.
   always_ff @(posedge clk) begin
      if (reset || recoverFlag_i) begin
         rrPtr_q <= '0;
         for (int unsigned p = 0; p < NUM_PORTS; p++) begin
            portPkt_q[p]  <= '0;
            portLane_q[p] <= '0;
         end
         if (reset) cnt_q <= '0;
      end else begin
         rrPtr_q <= rrPtr_d;
         for (int unsigned p = 0; p < NUM_PORTS; p++) begin
            portPkt_q[p]  <= portPkt_d[p];
            portLane_q[p] <= portLane_d[p];
         end
         cnt_q <= cnt_d;
      end
   end

   assign portPkt_o     = portPkt_q;
   assign portLane_o    = portLane_q;
   assign conflictCnt_o = cnt_q;

endmodule
